// File: rtl/inta_sequencer_if.sv
// Signal bundle between the INTA sequencer and the PIC core / host side.
// The sequencer drives the acknowledge and OCW2 write path through the master modport.
interface inta_sequencer_if;
  logic       EN;
  logic       INT;
  logic [7:0] D_IN;
  logic       AEOI;
  logic       SPEC_EOI;
  logic       SRV_DONE;
  logic       INTA;
  logic [7:0] VECTOR;
  logic       VEC_VALID;
  logic       SPURIOUS;
  logic [7:0] OCW_DATA;
  logic       OCW_WR;
  logic       BUSY;

  modport master (
    input  EN, INT, D_IN, AEOI, SPEC_EOI, SRV_DONE,
    output INTA, VECTOR, VEC_VALID, SPURIOUS, OCW_DATA, OCW_WR, BUSY
  );

  modport slave (
    output EN, INT, D_IN, AEOI, SPEC_EOI, SRV_DONE,
    input  INTA, VECTOR, VEC_VALID, SPURIOUS, OCW_DATA, OCW_WR, BUSY
  );
endinterface

// File: rtl/inta_sequencer.sv
// Two-pulse INTA acknowledge sequencer with vector capture and OCW2 end-of-interrupt issue.
// All outputs are registered and derived from the next state, so they change on the same edge as the FSM.
module inta_sequencer #(
  parameter int unsigned INTA_WIDTH = 2,
  parameter int unsigned INTA_GAP   = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  inta_sequencer_if.master bus
);

  // A zero parameter behaves as one cycle.
  localparam logic [7:0] WIDTH_LOAD = (INTA_WIDTH > 1) ? 8'(INTA_WIDTH - 1) : 8'd0;
  localparam logic [7:0] GAP_LOAD   = (INTA_GAP   > 1) ? 8'(INTA_GAP   - 1) : 8'd0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PULSE1, ST_GAP, ST_PULSE2, ST_ACK, ST_SERVICE, ST_EOI, ST_HOLDOFF
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       spur_q, spur_d;
  logic       aeoi_q, aeoi_d;
  logic       spec_q, spec_d;
  logic       inta_q, inta_d;
  logic [7:0] vector_q, vector_d;
  logic       vec_valid_q, vec_valid_d;
  logic       spurious_q, spurious_d;
  logic [7:0] ocw_data_q, ocw_data_d;
  logic       ocw_wr_q, ocw_wr_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    spur_d      = spur_q;
    aeoi_d      = aeoi_q;
    spec_d      = spec_q;
    vector_d    = vector_q;
    ocw_data_d  = ocw_data_q;
    vec_valid_d = 1'b0;
    spurious_d  = 1'b0;
    ocw_wr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.EN && bus.INT) begin
          state_d = ST_PULSE1;
          cnt_d   = WIDTH_LOAD;
        end
      end
      ST_PULSE1: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          spur_d  = ~bus.INT;
          state_d = ST_PULSE2;
          cnt_d   = WIDTH_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PULSE2: begin
        if (cnt_q == '0) begin
          vector_d    = bus.D_IN;
          aeoi_d      = bus.AEOI;
          spec_d      = bus.SPEC_EOI;
          vec_valid_d = ~spur_q;
          spurious_d  = spur_q;
          state_d     = ST_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      // Strobe cycle: SRV_DONE is deliberately not looked at here.
      ST_ACK: begin
        cnt_d   = GAP_LOAD;
        state_d = (spur_q || aeoi_q) ? ST_HOLDOFF : ST_SERVICE;
      end
      ST_SERVICE: begin
        if (bus.SRV_DONE) begin
          state_d    = ST_EOI;
          ocw_wr_d   = 1'b1;
          ocw_data_d = spec_q ? {5'b01100, vector_q[2:0]} : 8'h20;
        end
      end
      ST_EOI: begin
        state_d = ST_HOLDOFF;
        cnt_d   = GAP_LOAD;
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inta_d = (state_d == ST_PULSE1) || (state_d == ST_PULSE2);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      spur_q      <= 1'b0;
      aeoi_q      <= 1'b0;
      spec_q      <= 1'b0;
      inta_q      <= 1'b0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
      ocw_data_q  <= '0;
      ocw_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spur_q      <= spur_d;
      aeoi_q      <= aeoi_d;
      spec_q      <= spec_d;
      inta_q      <= inta_d;
      vector_q    <= vector_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
      ocw_data_q  <= ocw_data_d;
      ocw_wr_q    <= ocw_wr_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.INTA      = inta_q;
  assign bus.VECTOR    = vector_q;
  assign bus.VEC_VALID = vec_valid_q;
  assign bus.SPURIOUS  = spurious_q;
  assign bus.OCW_DATA  = ocw_data_q;
  assign bus.OCW_WR    = ocw_wr_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed scenarios plus random traffic against a timeline reference model.
// The model predicts outputs from the edge count since the sequence started.
module tb_inta_sequencer;
  localparam int W = 2;
  localparam int G = 2;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  inta_sequencer_if bus();

  inta_sequencer #(.INTA_WIDTH(W), .INTA_GAP(G)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model state: edge index, start edge of the running sequence, release edge.
  int         e = 0;
  int         s0 = 0;
  int         idle_at = -1;
  bit         active = 0;
  bit         in_svc = 0;
  bit         spur_m = 0, aeoi_m = 0, spec_m = 0;
  logic [7:0] vec_m = 8'h00, ocw_m = 8'h00;
  bit         vv_m = 0, sp_m = 0, wr_m = 0, inta_m = 0, busy_m = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int k;
    vv_m = 0; sp_m = 0; wr_m = 0;
    if (!active) begin
      if (bus.EN && bus.INT) begin
        active = 1; s0 = e; in_svc = 0; idle_at = -1;
      end
    end else begin
      k = e - s0;
      if (k == W + G) spur_m = !bus.INT;
      if (k == 2*W + G) begin
        vec_m = bus.D_IN; aeoi_m = bus.AEOI; spec_m = bus.SPEC_EOI;
        vv_m = !spur_m; sp_m = spur_m;
      end else if (k == 2*W + G + 1) begin
        if (spur_m || aeoi_m) idle_at = e + G;
        else in_svc = 1;
      end else if (in_svc && bus.SRV_DONE) begin
        in_svc = 0; wr_m = 1;
        ocw_m = spec_m ? {5'b01100, vec_m[2:0]} : 8'h20;
        idle_at = e + 1 + G;
      end
      if (e == idle_at) active = 0;
    end
    k = e - s0;
    inta_m = active && ((k < W) || (k >= W + G && k < 2*W + G));
    busy_m = active;
    e++;
  endtask

  task automatic check_all();
    chk("inta",      8'(bus.INTA),      8'(inta_m));
    chk("busy",      8'(bus.BUSY),      8'(busy_m));
    chk("vec_valid", 8'(bus.VEC_VALID), 8'(vv_m));
    chk("spurious",  8'(bus.SPURIOUS),  8'(sp_m));
    chk("ocw_wr",    8'(bus.OCW_WR),    8'(wr_m));
    chk("vector",    bus.VECTOR,        vec_m);
    chk("ocw_data",  bus.OCW_DATA,      ocw_m);
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    active = 0; in_svc = 0; spur_m = 0; aeoi_m = 0; spec_m = 0;
    vec_m = 8'h00; ocw_m = 8'h00;
    vv_m = 0; sp_m = 0; wr_m = 0; inta_m = 0; busy_m = 0;
    chk("rst_inta", 8'(bus.INTA), 8'h00);
    check_all();
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic set_in(input bit en, input bit intr, input logic [7:0] d,
                        input bit aeoi, input bit spec, input bit srv);
    bus.EN = en; bus.INT = intr; bus.D_IN = d;
    bus.AEOI = aeoi; bus.SPEC_EOI = spec; bus.SRV_DONE = srv;
  endtask

  initial begin
    set_in(0, 0, 8'h00, 0, 0, 0);
    do_reset();

    // Non-specific EOI
    set_in(1, 1, 8'h0B, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      if (i == 7) bus.INT = 0;
      bus.SRV_DONE = (i == 10);
      step();
      if (i == 6)  begin chk("t1_vv", 8'(bus.VEC_VALID), 8'h01); chk("t1_vec", bus.VECTOR, 8'h0B); end
      if (i == 10) begin chk("t1_wr", 8'(bus.OCW_WR), 8'h01); chk("t1_ocw", bus.OCW_DATA, 8'h20); end
      if (i == 13) chk("t1_busy", 8'(bus.BUSY), 8'h00);
    end

    // Specific EOI
    set_in(1, 1, 8'h45, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      if (i == 7) bus.INT = 0;
      bus.SRV_DONE = (i == 9);
      step();
      if (i == 6) chk("t2_vec", bus.VECTOR, 8'h45);
      if (i == 9) begin chk("t2_wr", 8'(bus.OCW_WR), 8'h01); chk("t2_ocw", bus.OCW_DATA, 8'h65); end
    end

    // Automatic EOI: SRV_DONE held high must not cause a write
    set_in(1, 1, 8'h0F, 1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 7) bus.INT = 0;
      step();
      if (i == 6) begin chk("t3_vv", 8'(bus.VEC_VALID), 8'h01); chk("t3_vec", bus.VECTOR, 8'h0F); end
      if (i == 8) chk("t3_busy_hi", 8'(bus.BUSY), 8'h01);
      if (i == 9) chk("t3_busy_lo", 8'(bus.BUSY), 8'h00);
    end

    // Spurious: INT drops after pulse 1
    set_in(1, 1, 8'h0F, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 3) bus.INT = 0;
      step();
      if (i == 4) chk("t4_pulse2", 8'(bus.INTA), 8'h01);
      if (i == 6) begin chk("t4_sp", 8'(bus.SPURIOUS), 8'h01); chk("t4_vv", 8'(bus.VEC_VALID), 8'h00); end
    end

    // Reset during pulse 2
    set_in(1, 1, 8'h33, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("t5_pre_inta", 8'(bus.INTA), 8'h01);
    bus.INT = 0;
    do_reset();
    bus.SRV_DONE = 1;
    for (int i = 0; i < 10; i++) step();

    // EN low blocks the start
    set_in(0, 1, 8'h21, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 9) chk("t6_idle", 8'(bus.BUSY), 8'h00);
    end
    bus.EN = 1;
    step();
    chk("t6_start", 8'(bus.INTA), 8'h01);
    bus.EN = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) bus.INT = 0;
      bus.SRV_DONE = (i >= 10);
      step();
    end

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      set_in(($urandom % 4) != 0, ($urandom % 3) != 0, 8'($urandom),
             ($urandom % 3) == 0, ($urandom % 2) == 1, ($urandom % 5) == 0);
      if (i == 400) begin
        bus.INT = 0;
        do_reset();
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
Host-side counterpart to the PIC priority resolver. It watches INT, issues the two-pulse INTA acknowledge sequence, captures the interrupt vector from the PIC data bus on the second pulse, and hands the vector to the host. When the host reports the service routine done, it issues the OCW2 end-of-interrupt command, non-specific or specific. It sits between the PIC core (INT, INTA, data bus, OCW write path) and the host/CPU model.

Parameters:
INTA_WIDTH, 2, cycles INTA is held high per pulse (1..255)
INTA_GAP, 2, cycles INTA is low between pulse 1 and pulse 2; also the post-sequence holdoff length (1..255)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
EN  input  1  enables starting a new acknowledge sequence
INT  input  1  interrupt request from PIC, same clock domain
D_IN  input  8  PIC data bus, valid during pulse 2
AEOI  input  1  automatic EOI mode (no OCW2 issued)
SPEC_EOI  input  1  1: specific EOI, 0: non-specific EOI
SRV_DONE  input  1  host service routine complete (level or pulse)
INTA  output  1  interrupt acknowledge to PIC, active high
VECTOR  output  8  last captured vector
VEC_VALID  output  1  one-cycle strobe, VECTOR updated
SPURIOUS  output  1  one-cycle strobe, INT vanished mid-sequence
OCW_DATA  output  8  OCW2 command byte
OCW_WR  output  1  one-cycle OCW2 write strobe
BUSY  output  1  high in every state except IDLE

Behaviour:
- Reset (async, RESET_N=0): state IDLE; INTA=0, VECTOR=0, VEC_VALID=0, SPURIOUS=0, OCW_DATA=0, OCW_WR=0, BUSY=0. All outputs are registered. INTA drops immediately on reset, including mid-pulse.
- One 8-bit down-counter times the pulses, the gap and the holdoff.
- States: IDLE, PULSE1, GAP, PULSE2, SERVICE, EOI, HOLDOFF.
- IDLE: if EN=1 and INT=1 at a rising edge, go to PULSE1. INTA rises in the next cycle. EN=0 only blocks leaving IDLE; a sequence already in progress always completes.
- PULSE1: INTA=1 for INTA_WIDTH cycles, then GAP.
- GAP: INTA=0 for INTA_GAP cycles. INT is sampled on the last GAP cycle into a spurious flag (flag=1 if INT=0). Then PULSE2.
- PULSE2: INTA=1 for INTA_WIDTH cycles. It runs even when the spurious flag is set, because the protocol requires two pulses.
  - D_IN is sampled at the edge ending the last PULSE2 cycle; VECTOR takes D_IN whether or not the flag is set.
  - AEOI and SPEC_EOI are sampled at the same edge.
- After capture, in the next cycle:
  - flag set: SPURIOUS=1 for one cycle, VEC_VALID stays 0, go to HOLDOFF, no EOI.
  - else VEC_VALID=1 for one cycle; go to HOLDOFF if AEOI=1, otherwise to SERVICE.
- Timing with defaults: INT seen at edge 0 gives INTA high in cycles 1-2, low in 3-4, high in 5-6, and VEC_VALID in cycle 7.
- SERVICE: INTA=0. Wait for SRV_DONE=1, sampled only in this state; SRV_DONE in any other state is ignored. On SRV_DONE go to EOI.
- EOI: OCW_WR=1 for exactly one cycle, then HOLDOFF.
  - OCW_DATA = 8'h20 if SPEC_EOI=0.
  - OCW_DATA = {5'b01100, VECTOR[2:0]} if SPEC_EOI=1.
  - OCW_DATA holds its value until the next EOI.
- HOLDOFF: INTA_GAP cycles with INTA=0, then IDLE. This prevents re-acknowledging an INT the PIC has not yet dropped. A new sequence may start from IDLE on the following edge.
- VECTOR holds its value until the next capture.
- Simultaneous events: entering SERVICE and SRV_DONE in the same cycle does not trigger EOI. SRV_DONE must be seen while the state is SERVICE, so the earliest OCW_WR is 2 cycles after VEC_VALID.
- Parameters of 0 are illegal; the implementation may treat 0 as 1.

Test Plan:
- Defaults, INT=1 at edge 0, D_IN=8'h0B in cycles 5-6, AEOI=0, SPEC_EOI=0 -> INTA high in cycles 1-2 and 5-6; VEC_VALID and VECTOR=8'h0B in cycle 7; SRV_DONE in cycle 10 -> OCW_WR=1 with OCW_DATA=8'h20 in cycle 11; BUSY=0 from cycle 14.
- SPEC_EOI=1, D_IN=8'h45 -> VECTOR=8'h45, OCW_DATA=8'h65 on OCW_WR.
- AEOI=1, D_IN=8'h0F -> VEC_VALID with 8'h0F; OCW_WR never asserts; BUSY low 3 cycles after VEC_VALID.
- INT=1 through pulse 1, INT=0 from cycle 3, D_IN=8'h0F -> pulse 2 still occurs; SPURIOUS=1 in cycle 7, VEC_VALID=0, no OCW_WR.
- RESET_N=0 in cycle 5 (during PULSE2) -> INTA=0 immediately, all outputs at reset values; after release with INT=0, no VEC_VALID and no OCW_WR.
- EN=0, INT=1 for 10 cycles -> INTA stays 0, BUSY=0; EN=1 at edge 10 -> INTA=1 in cycle 11.
